// File: rtl/io_stream_buf_if.sv
// Stream buffer bus: sampled source side plus consumer pop side.
// The buffer takes the slave modport, the driver the master modport.
interface io_stream_buf_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 128,
    parameter int DIVW  = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             en;
    logic [WIDTH-1:0] in;
    logic [DIVW-1:0]  clkdiv;
    logic             outclk;
    logic             readdone;
    logic [WIDTH-1:0] out;
    logic             toread;
    logic [LW-1:0]    level;
    logic             afull;
    logic [15:0]      drops;
    logic             clr_drops;

    modport master (
        output en, in, clkdiv, readdone, clr_drops,
        input  outclk, out, toread, level, afull, drops
    );

    modport slave (
        input  en, in, clkdiv, readdone, clr_drops,
        output outclk, out, toread, level, afull, drops
    );
endinterface

// File: rtl/io_stream_buf.sv
// Divided-rate input sampler feeding an oldest-first FIFO, drained by
// an edge-triggered readdone handshake, with level/afull/drop reporting.
module io_stream_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 128,
    parameter int DIVW  = 16,
    parameter int AFULL = 112
) (
    input logic            clk,
    input logic            rst,
    io_stream_buf_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DIVW-1:0]  cnt;
    logic             outclk_q;
    logic [WIDTH-1:0] out_q;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [LW-1:0]    level;
    logic [15:0]      drops;
    logic             rd_q;

    logic tick;
    logic req;
    logic pop;
    logic full;
    logic push;
    logic drop;

    assign tick = bus.en && (cnt == bus.clkdiv);
    assign req  = bus.readdone && !rd_q;
    assign pop  = req && (level != '0);
    assign full = (level == LW'(DEPTH));
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign push = tick && (!full || pop);
    assign drop = tick && full && !pop;

    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_ptr] <= bus.in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            outclk_q <= 1'b0;
            out_q    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            drops    <= '0;
            rd_q     <= 1'b0;
        end else begin
            rd_q <= bus.readdone;
            if (!bus.en)
                cnt <= '0;
            else if (tick)
                cnt <= '0;
            else
                cnt <= cnt + DIVW'(1);
            if (tick)
                outclk_q <= ~outclk_q;
            if (pop) begin
                out_q  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (push && !pop)
                level <= level + LW'(1);
            else if (pop && !push)
                level <= level - LW'(1);
            if (bus.clr_drops)
                drops <= '0;
            else if (drop && drops != 16'hFFFF)
                drops <= drops + 16'd1;
        end
    end

    assign bus.outclk = outclk_q;
    assign bus.out    = out_q;
    assign bus.toread = (level != '0);
    assign bus.level  = level;
    assign bus.afull  = (level >= LW'(AFULL));
    assign bus.drops  = drops;
endmodule

// File: tb/tb_io_stream_buf.sv
// Self-checking bench for io_stream_buf against a queue-based model.
// Small FIFO (DEPTH=8, AFULL=6) so full and drop behaviour is reachable.
module tb_io_stream_buf;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int DIVW  = 16;
    localparam int AFULL = 6;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    io_stream_buf_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIVW(DIVW)) bus ();

    io_stream_buf #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .DIVW(DIVW), .AFULL(AFULL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_out;
    logic             m_outclk;
    logic [15:0]      m_drops;
    logic [DIVW-1:0]  m_ph;
    logic             m_rdq;

    task automatic cycle();
        logic tk, rq, pp, dr;
        int sz;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_out = '0; m_outclk = 1'b0; m_drops = '0;
            m_ph = '0; m_rdq = 1'b0;
        end else begin
            tk = 1'b0;
            if (bus.en) begin
                if (m_ph == bus.clkdiv) begin
                    tk = 1'b1; m_ph = '0;
                end else begin
                    m_ph = m_ph + 1'b1;
                end
            end else begin
                m_ph = '0;
            end
            rq = bus.readdone && !m_rdq;
            m_rdq = bus.readdone;
            sz = mq.size();
            pp = rq && (sz > 0);
            if (pp) m_out = mq.pop_front();
            dr = 1'b0;
            if (tk) begin
                m_outclk = !m_outclk;
                if (sz < DEPTH || pp) mq.push_back(bus.in);
                else dr = 1'b1;
            end
            if (bus.clr_drops) m_drops = '0;
            else if (dr && m_drops != 16'hFFFF) m_drops = m_drops + 1'b1;
        end
        #1;
    endtask

    task automatic pulse();
        bus.readdone = 1'b1; cycle();
        bus.readdone = 1'b0; cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.en = 1'b0; bus.readdone = 1'b0;
        bus.clr_drops = 1'b0;
        cycle(); cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic oc0;
        bus.in = '0; bus.clkdiv = '0;
        do_reset();
        n_chk++;
        if (bus.outclk !== 1'b0 || bus.out !== '0 || bus.toread !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a: outclk=%b out=%h toread=%b required 0 0 0",
                     bus.outclk, bus.out, bus.toread);
        end
        n_chk++;
        if (bus.level !== '0 || bus.afull !== 1'b0 || bus.drops !== '0) begin
            n_fail++;
            $display("FAIL reset_b: level=%0d afull=%b drops=%0d required 0 0 0",
                     bus.level, bus.afull, bus.drops);
        end
        oc0 = bus.outclk;
        for (int i = 0; i < 50; i++) begin
            bus.in = WIDTH'($urandom);
            cycle();
            n_chk++;
            if (bus.outclk !== oc0 || bus.level !== '0) begin
                n_fail++;
                $display("FAIL idle: outclk=%b level=%0d required %b 0",
                         bus.outclk, bus.level, oc0);
            end
        end
    endtask

    task automatic test_divider();
        logic [WIDTH-1:0] v;
        int toggles;
        logic prev;
        v = 16'h0001; toggles = 0;
        bus.clkdiv = 16'd3; bus.in = v; bus.en = 1'b1;
        prev = bus.outclk;
        for (int i = 0; i < 12; i++) begin
            cycle();
            n_chk++;
            if (bus.outclk !== m_outclk || bus.level !== LW'(mq.size())) begin
                n_fail++;
                $display("FAIL div_cyc%0d: outclk=%b level=%0d required %b %0d",
                         i, bus.outclk, bus.level, m_outclk, mq.size());
            end
            // first tick at the 4th edge after en, then every 4 edges
            n_chk++;
            if (bus.outclk !== ((i + 1) / 4 % 2 == 1)) begin
                n_fail++;
                $display("FAIL div_period%0d: outclk=%b", i, bus.outclk);
            end
            if (bus.outclk !== prev) begin
                toggles++; v = v + 1'b1; bus.in = v;
            end
            prev = bus.outclk;
        end
        bus.en = 1'b0;
        n_chk++;
        if (toggles != 3 || bus.level !== LW'(3)) begin
            n_fail++;
            $display("FAIL div_count: toggles=%0d level=%0d required 3 3",
                     toggles, bus.level);
        end
        for (int k = 1; k <= 3; k++) begin
            pulse();
            n_chk++;
            if (bus.out !== WIDTH'(k)) begin
                n_fail++;
                $display("FAIL div_data%0d: out=%h required %h", k, bus.out, k);
            end
        end
    endtask

    task automatic test_fifo_order();
        logic [WIDTH-1:0] w[3];
        w[0] = 16'hA001; w[1] = 16'hA002; w[2] = 16'hA003;
        bus.clkdiv = '0; bus.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in = w[i]; cycle();
        end
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse();
            n_chk++;
            if (bus.out !== w[i] || bus.out !== m_out) begin
                n_fail++;
                $display("FAIL order%0d: out=%h required %h", i, bus.out, w[i]);
            end
        end
        n_chk++;
        if (bus.toread !== 1'b0) begin
            n_fail++;
            $display("FAIL order_empty: toread=%b required 0", bus.toread);
        end
        pulse();
        n_chk++;
        if (bus.out !== 16'hA003 || bus.level !== '0) begin
            n_fail++;
            $display("FAIL order_extra: out=%h level=%0d required a003 0",
                     bus.out, bus.level);
        end
    endtask

    task automatic test_level_hold();
        bus.clkdiv = '0; bus.en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in = WIDTH'($urandom); cycle();
        end
        bus.en = 1'b0;
        bus.readdone = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        bus.readdone = 1'b0;
        cycle();
        n_chk++;
        if (bus.level !== LW'(4) || mq.size() != 4) begin
            n_fail++;
            $display("FAIL hold: level=%0d required 4", bus.level);
        end
        for (int i = 0; i < 4; i++) pulse();
        n_chk++;
        if (bus.level !== '0 || bus.out !== m_out) begin
            n_fail++;
            $display("FAIL hold_drain: level=%0d out=%h required 0 %h",
                     bus.level, bus.out, m_out);
        end
    endtask

    task automatic test_full();
        do_reset();
        bus.clkdiv = '0; bus.en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in = WIDTH'($urandom);
            cycle();
            n_chk++;
            if (bus.afull !== (i + 1 >= AFULL) || bus.level !== LW'(mq.size())) begin
                n_fail++;
                $display("FAIL full_cyc%0d: afull=%b level=%0d required %b %0d",
                         i, bus.afull, bus.level, (i + 1 >= AFULL), mq.size());
            end
        end
        bus.en = 1'b0;
        cycle();
        n_chk++;
        if (bus.level !== LW'(8) || bus.drops !== 16'd2) begin
            n_fail++;
            $display("FAIL full_end: level=%0d drops=%0d required 8 2",
                     bus.level, bus.drops);
        end
        bus.en = 1'b1; bus.clr_drops = 1'b1;
        cycle();
        bus.en = 1'b0; bus.clr_drops = 1'b0;
        cycle();
        n_chk++;
        if (bus.drops !== '0 || bus.level !== LW'(8)) begin
            n_fail++;
            $display("FAIL clr_drops: drops=%0d level=%0d required 0 8",
                     bus.drops, bus.level);
        end
    endtask

    task automatic test_full_pop();
        logic [WIDTH-1:0] oldest, last;
        oldest = mq[0];
        bus.in = 16'hBEEF; bus.clkdiv = '0;
        bus.en = 1'b1; bus.readdone = 1'b1;
        cycle();
        bus.en = 1'b0; bus.readdone = 1'b0;
        cycle();
        n_chk++;
        if (bus.level !== LW'(8) || bus.drops !== '0 || bus.out !== oldest) begin
            n_fail++;
            $display("FAIL full_pop: level=%0d drops=%0d out=%h required 8 0 %h",
                     bus.level, bus.drops, bus.out, oldest);
        end
        last = '0;
        for (int i = 0; i < 8; i++) begin
            pulse(); last = bus.out;
        end
        n_chk++;
        if (last !== 16'hBEEF || bus.toread !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pop_last: out=%h toread=%b required beef 0",
                     last, bus.toread);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                rst = 1'b1; bus.readdone = 1'b1;
                cycle(); cycle();
                rst = 1'b0;
            end
            if ($urandom_range(0, 15) == 0) bus.clkdiv = DIVW'($urandom_range(0, 3));
            bus.en = ($urandom_range(0, 9) != 0);
            bus.in = WIDTH'($urandom);
            bus.readdone = ($urandom_range(0, 2) == 0) ? ~bus.readdone : bus.readdone;
            bus.clr_drops = ($urandom_range(0, 40) == 0);
            cycle();
            n_chk++;
            if (bus.out !== m_out || bus.level !== LW'(mq.size()) ||
                bus.outclk !== m_outclk || bus.drops !== m_drops ||
                bus.toread !== (mq.size() != 0) ||
                bus.afull !== (mq.size() >= AFULL)) begin
                n_fail++;
                $display("FAIL rand%0d: out=%h lvl=%0d oc=%b dr=%0d req %h %0d %b %0d",
                         i, bus.out, bus.level, bus.outclk, bus.drops,
                         m_out, mq.size(), m_outclk, m_drops);
            end
        end
        bus.en = 1'b0; bus.readdone = 1'b0; bus.clr_drops = 1'b0;
    endtask

    initial begin
        bus.en = 1'b0; bus.in = '0; bus.clkdiv = '0;
        bus.readdone = 1'b0; bus.clr_drops = 1'b0;
        test_reset();
        test_divider();
        test_fifo_order();
        test_level_hold();
        test_full();
        test_full_pop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
